led_chain_transmitter: RTL and testbench

//  Parametrised serial transmitter for a daisy-chained WS2812-style LED string.

---
 rtl/led_chain_transmitter.sv | 102 ++++++++++
 tb/tb_led_chain_transmitter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_chain_transmitter.sv
// led_chain_transmitter: snapshots a frame of pixel words and serialises it as WS2812-style pulses plus a latch gap
module led_chain_transmitter #(
    parameter int N_LEDS       = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T0H_CYC      = 20,
    parameter int T1H_CYC      = 40,
    parameter int TBIT_CYC     = 63,
    parameter int TRST_CYC     = 3000,
    localparam int LW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1,
    localparam int BW = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [N_LEDS*BITS_PER_LED-1:0] pixels,
    output logic                           busy,
    output logic                           dout,
    output logic                           frame_done,
    output logic [LW-1:0]                  led_idx_dbg,
    output logic [BW-1:0]                  bit_idx_dbg
);
    localparam int NB   = N_LEDS * BITS_PER_LED;
    localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int MAXC = (TBIT_CYC > TRST_CYC) ? TBIT_CYC : TRST_CYC;
    localparam int TW   = $clog2(MAXC);
    localparam logic [TW-1:0] TBIT_END = TW'(TBIT_CYC - 1);
    localparam logic [TW-1:0] TRST_END = TW'(TRST_CYC - 1);
    localparam logic [TW-1:0] T0H      = TW'(T0H_CYC);
    localparam logic [TW-1:0] T1H      = TW'(T1H_CYC);
    localparam logic [LW-1:0] LED_LAST = LW'(N_LEDS - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(BITS_PER_LED - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   led_q, led_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [NB-1:0]   buf_q, buf_d;
    logic            dout_q, dout_d;
    logic [IW-1:0]   sel;

    // Next-state: frame sequencing, and dout precomputed from the next timer/index so the pin is registered
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        led_d   = led_q;
        bit_d   = bit_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                buf_d   = pixels;
                led_d   = '0;
                bit_d   = BIT_MSB;
                timer_d = '0;
            end
            SEND: if (timer_q == TBIT_END) begin
                timer_d = '0;
                if (bit_q != '0) bit_d = bit_q - 1'b1;
                else if (led_q != LED_LAST) begin
                    bit_d = BIT_MSB;
                    led_d = led_q + 1'b1;
                end else state_d = LATCH;
            end else timer_d = timer_q + 1'b1;
            LATCH: if (timer_q == TRST_END) begin
                state_d = IDLE;
                timer_d = '0;
                led_d   = '0;
                bit_d   = '0;
            end else timer_d = timer_q + 1'b1;
            default: state_d = IDLE;
        endcase
        sel    = IW'(int'(led_d) * BITS_PER_LED + int'(bit_d));
        dout_d = (state_d == SEND) && (timer_d < (buf_d[sel] ? T1H : T0H));
    end

    // State registers; async reset drops dout and busy immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            timer_q <= '0;
            led_q   <= '0;
            bit_q   <= '0;
            buf_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            led_q   <= led_d;
            bit_q   <= bit_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign dout        = dout_q;
    assign frame_done  = (state_q == LATCH) && (timer_q == TRST_END);
    assign led_idx_dbg = led_q;
    assign bit_idx_dbg = bit_q;
endmodule

// File: tb/tb_led_chain_transmitter.sv
// tb_led_chain_transmitter: table, directed and random checks of the LED chain transmitter
module tb_led_chain_transmitter;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, busy, dout, fd;
    logic [7:0]  pixels = '0;
    logic [0:0]  led_dbg;
    logic [1:0]  bit_dbg;

    logic         start6 = 1'b0, busy6, dout6, fd6;
    logic [191:0] pixels6 = '0;
    logic [2:0]   led6;
    logic [4:0]   bit6;

    led_chain_transmitter #(.N_LEDS(2), .BITS_PER_LED(4), .T0H_CYC(2), .T1H_CYC(4),
                            .TBIT_CYC(6), .TRST_CYC(10)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pixels(pixels), .busy(busy), .dout(dout),
        .frame_done(fd), .led_idx_dbg(led_dbg), .bit_idx_dbg(bit_dbg));

    led_chain_transmitter dut6 (
        .clk(clk), .rstn(rstn), .start(start6), .pixels(pixels6), .busy(busy6), .dout(dout6),
        .frame_done(fd6), .led_idx_dbg(led6), .bit_idx_dbg(bit6));

    int checks = 0, errors = 0;
    localparam logic [63:0] EB = 64'h03FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EF = 64'h0200_0000_0000_0000;

    logic [63:0] dlog, blog, flog;
    logic [0:0]  led_log [1:60];
    logic [1:0]  bit_log [1:60];

    typedef struct { logic [7:0] px; logic [31:0] w; } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // expected waveform from the bit rules: LED0 first, MSB first, high 4 for '1' / 2 for '0', period 6
    function automatic logic [63:0] model(input logic [7:0] px);
        logic [63:0] w = '0;
        int pos = 0;
        for (int led = 0; led < 2; led++)
            for (int b = 3; b >= 0; b--) begin
                int hi = px[led*4+b] ? 4 : 2;
                for (int t = 0; t < 6; t++) begin
                    w[pos] = (t < hi);
                    pos++;
                end
            end
        return w;
    endfunction

    // high width of each 6-cycle slot, first slot in top nibble; F marks a non-contiguous pulse
    function automatic logic [31:0] widths(input logic [63:0] d);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            logic [5:0] slot = d[i*6 +: 6];
            int n = $countones(slot);
            logic [5:0] pre = 6'((1 << n) - 1);
            r[31-4*i -: 4] = (slot == pre) ? 4'(n) : 4'hF;
        end
        return r;
    endfunction

    task automatic frame(input logic [7:0] px, input logic [63:0] smask, input int chg, input logic [7:0] chg_px);
        dlog = '0; blog = '0; flog = '0;
        @(negedge clk);
        pixels = px;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            dlog[k-1] = dout; blog[k-1] = busy; flog[k-1] = fd;
            led_log[k] = led_dbg; bit_log[k] = bit_dbg;
            start = smask[k-1];
            if (k == chg) pixels = chg_px;
        end
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hA5, 32'h2424_4242};
        tbl[1] = '{8'h00, 32'h2222_2222};
        tbl[2] = '{8'hFF, 32'h4444_4444};
        tbl[3] = '{8'h3C, 32'h4422_2244};
        tbl[4] = '{8'h81, 32'h2224_4222};
        repeat (3) @(negedge clk);
        check("reset", 64'({busy, dout, fd, led_dbg, bit_dbg, busy6, dout6, fd6, led6, bit6}), 64'd0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame(tbl[i].px, '0, 0, 8'h00);
            check($sformatf("widths_%0d", i), 64'(widths(dlog)), 64'(tbl[i].w));
            check($sformatf("latch_low_%0d", i), 64'(dlog[59:48]), 64'd0);
            check($sformatf("busy_%0d", i), blog, EB);
            check($sformatf("done_%0d", i), flog, EF);
            if (i == 0)
                check("dbg_idx", 64'({led_log[1], bit_log[1], led_log[7], bit_log[7], led_log[25], bit_log[25],
                                      led_log[50], bit_log[50], led_log[60], bit_log[60]}),
                      64'(15'b011_010_111_100_000));
        end
        frame(8'hA5, '0, 5, 8'h00);
        check("snapshot", 64'(widths(dlog)), 64'h2424_4242);
        frame(8'hA5, (64'd1 << 2) | (64'd1 << 19) | (64'd1 << 57), 0, 8'h00);
        check("ignore_start_busy", blog, EB);
        check("ignore_start_done", flog, EF);
        repeat (5) @(negedge clk);
        check("ignore_start_idle", 64'(busy), 64'd0);
        frame(8'h3C, '1, 0, 8'h00);
        check("b2b_first", 64'(dlog[47:0]), 64'(model(8'h3C) & 64'h0000_FFFF_FFFF_FFFF));
        check("b2b_gap_rise", 64'(dlog[59:48]), 64'h800);
        check("b2b_busy", blog, 64'h0BFF_FFFF_FFFF_FFFF);
        check("b2b_done", flog, EF);
        wait_idle(200);
        @(negedge clk);
        pixels = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("rst_pre", 64'({dout, busy}), 64'd3);
        #1 rstn = 1'b0;
        #1 check("rst_async", 64'({dout, busy, fd, led_dbg, bit_dbg}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        check("rst_idle", 64'(busy), 64'd0);
        frame(8'hA5, '0, 0, 8'h00);
        check("rst_refresh", 64'(widths(dlog)), 64'h2424_4242);
        check("rst_refresh_done", flog, EF);
        repeat (20) begin
            logic [7:0] px = 8'($urandom);
            logic [63:0] sm = {32'($urandom), 32'($urandom)} & EB;
            frame(px, sm, int'($urandom_range(1, 50)), 8'($urandom));
            check($sformatf("rand_dout_%02h", px), dlog, model(px));
            check("rand_busy", blog, EB);
            check("rand_done", flog, EF);
        end
        begin
            int n = 1, hi = 0, rises = 0;
            logic prev = 1'b0;
            @(negedge clk);
            pixels6 = '1;
            start6 = 1'b1;
            @(negedge clk);
            start6 = 1'b0;
            while (!fd6 && n < 20000) begin
                hi += int'(dout6);
                if (dout6 && !prev) rises++;
                prev = dout6;
                @(negedge clk);
                n++;
            end
            check("def_len", 64'(n), 64'd15096);
            check("def_high", 64'(hi), 64'd7680);
            check("def_rises", 64'(rises), 64'd192);
            @(negedge clk);
            check("def_idle", 64'(busy6), 64'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
